// File: rtl/tx_fifo_write_arb_pkg.sv
// Shared types and reset values for the tx_fifo write-port arbiter.
// The FSM states, the round-robin grant owner and the counter width helper live here.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND_BLK,
    SEND_STAT
  } state_t;

  typedef enum logic {
    GNT_BLK,
    GNT_STAT
  } grant_t;

  localparam state_t STATE_RST = IDLE;
  // The STAT reset value makes the first tied request go to the block producer.
  localparam grant_t GRANT_RST = GNT_STAT;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_fifo_write_arb_if.sv
// Producer and FIFO-side signals of the write arbiter.
// The master modport is the arbiter's view; the slave modport is the producers' and tx_fifo's view.
interface tx_fifo_write_arb_if #(
  parameter int NUM_BYTES = 8,
  parameter int BYTE_W    = 8
);

  logic                          blk_valid;
  logic [NUM_BYTES*BYTE_W-1:0]   blk_data;
  logic                          blk_ready;
  logic                          stat_valid;
  logic [BYTE_W-1:0]             stat_data;
  logic                          stat_ready;
  logic                          fifo_full;
  logic                          write_enable;
  logic [BYTE_W-1:0]             write_data;
  logic                          busy;

  modport master (
    input  blk_valid, blk_data, stat_valid, stat_data, fifo_full,
    output blk_ready, stat_ready, write_enable, write_data, busy
  );

  modport slave (
    output blk_valid, blk_data, stat_valid, stat_data, fifo_full,
    input  blk_ready, stat_ready, write_enable, write_data, busy
  );

endinterface

// File: rtl/tx_fifo_write_arb_blk_serializer.sv
// Holds one DES block and presents it MSB byte first, one byte per shift.
// The FSM drives load/shift; with neither asserted everything holds.
module blk_serializer
  import tx_arb_pkg::*;
#(
  parameter int NUM_BYTES = 8,
  parameter int BYTE_W    = 8
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        load,
  input  logic                        shift,
  input  logic [NUM_BYTES*BYTE_W-1:0] load_data,
  output logic [BYTE_W-1:0]           top_byte,
  output logic                        last_byte
);

  localparam int BLK_W = NUM_BYTES * BYTE_W;
  localparam int CNT_W = cnt_w(NUM_BYTES);

  logic [BLK_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    if (load) begin
      shift_d    = load_data;
      byte_cnt_d = '0;
    end else if (shift) begin
      shift_d    = shift_q << BYTE_W;
      byte_cnt_d = byte_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign top_byte  = shift_q[BLK_W-1 -: BYTE_W];
  assign last_byte = (byte_cnt_q == CNT_W'(NUM_BYTES - 1));

endmodule

// File: rtl/tx_fifo_write_arb.sv
// Shares the tx_fifo write port between the DES block producer and the status producer.
// Round-robin grants in IDLE; blocks are sent atomically; every send is followed by one dead IDLE cycle.
module tx_fifo_write_arb
  import tx_arb_pkg::*;
#(
  parameter int NUM_BYTES = 8,
  parameter int BYTE_W    = 8
) (
  input logic                     clk,
  input logic                     n_rst,
  tx_fifo_write_arb_if.master     bus
);

  state_t            state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic              cool_q, cool_d;
  logic [BYTE_W-1:0] stat_q, stat_d;

  logic              blk_ready;
  logic              stat_ready;
  logic              write_enable;
  logic              ser_load;
  logic              ser_shift;
  logic              last_byte;
  logic [BYTE_W-1:0] top_byte;

  blk_serializer #(
    .NUM_BYTES (NUM_BYTES),
    .BYTE_W    (BYTE_W)
  ) u_ser (
    .clk       (clk),
    .n_rst     (n_rst),
    .load      (ser_load),
    .shift     (ser_shift),
    .load_data (bus.blk_data),
    .top_byte  (top_byte),
    .last_byte (last_byte)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cool_d       = 1'b0;
    stat_d       = stat_q;
    blk_ready    = 1'b0;
    stat_ready   = 1'b0;
    write_enable = 1'b0;
    ser_load     = 1'b0;
    ser_shift    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // cool_q marks the mandatory grant-free IDLE cycle right after a send.
        if (!cool_q) begin
          if (bus.blk_valid && (!bus.stat_valid || last_grant_q == GNT_STAT)) begin
            blk_ready    = 1'b1;
            ser_load     = 1'b1;
            last_grant_d = GNT_BLK;
            state_d      = SEND_BLK;
          end else if (bus.stat_valid) begin
            stat_ready   = 1'b1;
            stat_d       = bus.stat_data;
            last_grant_d = GNT_STAT;
            state_d      = SEND_STAT;
          end
        end
      end

      SEND_BLK: begin
        write_enable = !bus.fifo_full;
        if (write_enable) begin
          ser_shift = 1'b1;
          if (last_byte) begin
            state_d = IDLE;
            cool_d  = 1'b1;
          end
        end
      end

      SEND_STAT: begin
        write_enable = !bus.fifo_full;
        if (write_enable) begin
          state_d = IDLE;
          cool_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: async reset returns state to IDLE at once, which drops write_enable without waiting for clk.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= STATE_RST;
      last_grant_q <= GRANT_RST;
      cool_q       <= 1'b0;
      stat_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cool_q       <= cool_d;
      stat_q       <= stat_d;
    end
  end

  assign bus.blk_ready    = blk_ready;
  assign bus.stat_ready   = stat_ready;
  assign bus.write_enable = write_enable;
  assign bus.write_data   = (state_q == SEND_STAT) ? stat_q : top_byte;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_tx_fifo_write_arb.sv
// Directed bench for tx_fifo_write_arb: expected FIFO bytes are queued at each grant
// and popped by a write monitor; handshake timing is checked step by step.
module tb_tx_fifo_write_arb;

  localparam int NB = 8;
  localparam int BW = 8;

  logic clk;
  logic n_rst;

  tx_fifo_write_arb_if #(.NUM_BYTES(NB), .BYTE_W(BW)) bus ();

  tx_fifo_write_arb #(.NUM_BYTES(NB), .BYTE_W(BW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [BW-1:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_blk(input logic [NB*BW-1:0] d);
    for (int i = NB - 1; i >= 0; i--) exp_q.push_back(d[i*BW +: BW]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},   bus.write_enable, 0);
    check({tag, "_wd"},   bus.write_data,   0);
    check({tag, "_brdy"}, bus.blk_ready,    0);
    check({tag, "_srdy"}, bus.stat_ready,   0);
    check({tag, "_busy"}, bus.busy,         0);
  endtask

  task automatic do_reset();
    n_rst          = 1'b0;
    bus.blk_valid  = 1'b0;
    bus.blk_data   = '0;
    bus.stat_valid = 1'b0;
    bus.stat_data  = '0;
    bus.fifo_full  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    exp_q.delete();
    n_rst = 1'b1;
  endtask

  // Eight consecutive write cycles of a block; the monitor checks the bytes themselves.
  task automatic expect_block_writes(input string tag);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      check({tag, "_we"},   bus.write_enable, 1);
      check({tag, "_busy"}, bus.busy,         1);
      next_cycle();
    end
  endtask

  always @(negedge clk) begin
    if (n_rst === 1'b1 && bus.write_enable === 1'b1) begin
      check("sb_pending", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("sb_data", bus.write_data, exp_q.pop_front());
    end
  end

  initial begin
    n_rst = 1'b0;
    #2;
    do_reset();

    // 1: single block
    bus.blk_valid = 1'b1;
    bus.blk_data  = 64'h0102030405060708;
    @(negedge clk);
    check("t1_blk_ready", bus.blk_ready, 1);
    check("t1_stat_ready", bus.stat_ready, 0);
    push_blk(64'h0102030405060708);
    next_cycle();
    bus.blk_valid = 1'b0;
    expect_block_writes("t1");
    @(negedge clk);
    check("t1_done_busy", bus.busy, 0);
    check("t1_done_we", bus.write_enable, 0);
    next_cycle();
    check("t1_drained", exp_q.size(), 0);

    // 2: status only
    bus.stat_valid = 1'b1;
    bus.stat_data  = 8'hA5;
    @(negedge clk);
    check("t2_stat_ready", bus.stat_ready, 1);
    check("t2_blk_ready", bus.blk_ready, 0);
    exp_q.push_back(8'hA5);
    next_cycle();
    bus.stat_valid = 1'b0;
    @(negedge clk);
    check("t2_we", bus.write_enable, 1);
    check("t2_wd", bus.write_data, 8'hA5);
    next_cycle();
    @(negedge clk);
    check("t2_done_busy", bus.busy, 0);
    check("t2_done_we", bus.write_enable, 0);
    next_cycle();

    // 3: simultaneous requests from reset, alternating grants
    do_reset();
    bus.blk_valid  = 1'b1;
    bus.stat_valid = 1'b1;
    bus.blk_data   = 64'h1112131415161718;
    bus.stat_data  = 8'h3C;
    @(negedge clk);
    check("t3_blk_first", bus.blk_ready, 1);
    check("t3_stat_wait", bus.stat_ready, 0);
    push_blk(64'h1112131415161718);
    for (int i = 0; i < NB + 1; i++) begin
      next_cycle();
      @(negedge clk);
      check("t3_no_grant_blk", {bus.blk_ready, bus.stat_ready}, 0);
    end
    next_cycle();
    @(negedge clk);
    check("t3_stat_second", bus.stat_ready, 1);
    check("t3_blk_wait", bus.blk_ready, 0);
    exp_q.push_back(8'h3C);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      check("t3_no_grant_stat", {bus.blk_ready, bus.stat_ready}, 0);
    end
    next_cycle();
    @(negedge clk);
    check("t3_blk_third", bus.blk_ready, 1);
    check("t3_stat_third", bus.stat_ready, 0);
    push_blk(64'h1112131415161718);
    next_cycle();
    bus.blk_valid  = 1'b0;
    bus.stat_valid = 1'b0;
    expect_block_writes("t3");
    @(negedge clk);
    check("t3_done_busy", bus.busy, 0);
    next_cycle();
    check("t3_drained", exp_q.size(), 0);

    // 4: backpressure after the third byte
    bus.blk_valid = 1'b1;
    bus.blk_data  = 64'hDEADBEEF00112233;
    @(negedge clk);
    check("t4_blk_ready", bus.blk_ready, 1);
    push_blk(64'hDEADBEEF00112233);
    next_cycle();
    bus.blk_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_pre_we", bus.write_enable, 1);
      next_cycle();
    end
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_full_we", bus.write_enable, 0);
      check("t4_full_busy", bus.busy, 1);
      next_cycle();
    end
    bus.fifo_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_post_we", bus.write_enable, 1);
      next_cycle();
    end
    @(negedge clk);
    check("t4_done_busy", bus.busy, 0);
    next_cycle();
    check("t4_drained", exp_q.size(), 0);

    // 5: reset after four bytes, then a fresh block restarts at its MSB
    bus.blk_valid = 1'b1;
    bus.blk_data  = 64'h1122334455667788;
    @(negedge clk);
    check("t5_blk_ready", bus.blk_ready, 1);
    push_blk(64'h1122334455667788);
    next_cycle();
    bus.blk_valid = 1'b0;
    repeat (4) next_cycle();
    #1;
    check("t5_pre_we", bus.write_enable, 1);
    check("t5_pre_sb", exp_q.size(), 4);
    n_rst = 1'b0;
    #1;
    check_idle_outputs("t5_async");
    exp_q.delete();
    next_cycle();
    n_rst = 1'b1;
    bus.blk_valid = 1'b1;
    bus.blk_data  = 64'hA1A2A3A4A5A6A7A8;
    @(negedge clk);
    check("t5_new_ready", bus.blk_ready, 1);
    push_blk(64'hA1A2A3A4A5A6A7A8);
    next_cycle();
    bus.blk_valid = 1'b0;
    @(negedge clk);
    check("t5_first_byte", bus.write_data, 8'hA1);
    next_cycle();
    repeat (NB - 1) next_cycle();
    @(negedge clk);
    check("t5_done_busy", bus.busy, 0);
    next_cycle();
    check("t5_drained", exp_q.size(), 0);

    // 6: status raised mid-block waits for the block and the dead cycle
    bus.blk_valid = 1'b1;
    bus.blk_data  = 64'hC0C1C2C3C4C5C6C7;
    @(negedge clk);
    check("t6_blk_ready", bus.blk_ready, 1);
    push_blk(64'hC0C1C2C3C4C5C6C7);
    next_cycle();
    bus.blk_valid = 1'b0;
    @(negedge clk);
    check("t6_first_we", bus.write_enable, 1);
    next_cycle();
    bus.stat_valid = 1'b1;
    bus.stat_data  = 8'h5A;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      check("t6_stat_held", bus.stat_ready, 0);
      next_cycle();
    end
    @(negedge clk);
    check("t6_stat_ready", bus.stat_ready, 1);
    exp_q.push_back(8'h5A);
    next_cycle();
    bus.stat_valid = 1'b0;
    @(negedge clk);
    check("t6_stat_we", bus.write_enable, 1);
    check("t6_stat_wd", bus.write_data, 8'h5A);
    next_cycle();
    @(negedge clk);
    check("t6_done_busy", bus.busy, 0);
    next_cycle();
    check("t6_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
